// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and helpers for the AXI-stream packet generator.
package axis_pkt_gen_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    // Widest tkeep the helper can describe; callers size-cast the result to their KW.
    localparam int KMAX = 256;

    // Final-beat tkeep: low (len mod kw) bytes valid, or all kw bytes when len fills the beat.
    function automatic logic [KMAX-1:0] last_keep(input logic [15:0] len, input int kw);
        logic [KMAX-1:0] m;
        int              r;
        r = int'(len) % kw;
        m = '0;
        for (int i = 0; i < KMAX; i++)
            m[i] = (r == 0) ? (i < kw) : (i < r);
        return m;
    endfunction

endpackage

// File: rtl/axis_pkt_pattern.sv
// Combinational payload pattern: lane i of beat b in packet p is {p[15:0], b*(DW/32)+i}.
module axis_pkt_pattern #(
    parameter int DW = 512
) (
    input  logic [15:0]   i_pkt,
    input  logic [15:0]   i_beat,
    output logic [DW-1:0] o_data
);

    localparam int NL = DW / 32;

    logic [15:0] w_base;

    assign w_base = i_beat * 16'(NL);

    for (genvar i = 0; i < NL; i++) begin : g_lane
        assign o_data[32*i +: 32] = {i_pkt, w_base + 16'(i)};
    end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-stream packet source: programmable count, byte length and inter-packet gap,
// deterministic payload, full tready backpressure with registered outputs.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int DW = 512,
    parameter int KW = 64,
    parameter int UW = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          stop,
    input  logic [31:0]   cfg_pkt_count,
    input  logic [15:0]   cfg_pkt_len,
    input  logic [7:0]    cfg_gap,
    output logic          busy,
    output logic [31:0]   pkts_sent,
    output logic [DW-1:0] axis_out_tdata,
    output logic [KW-1:0] axis_out_tkeep,
    output logic [UW-1:0] axis_out_tuser,
    output logic          axis_out_tlast,
    output logic          axis_out_tvalid,
    input  logic          axis_out_tready
);

    state_t        r_state;
    logic [31:0]   r_cnt;
    logic [31:0]   r_p;
    logic [31:0]   r_pkts_sent;
    logic [15:0]   r_len;
    logic [15:0]   r_beats;
    logic [15:0]   r_b;
    logic [7:0]    r_gap;
    logic [7:0]    r_gap_cnt;
    logic          r_stop_req;
    logic          r_busy;
    logic          r_tvalid;
    logic          r_tlast;
    logic [KW-1:0] r_tkeep;
    logic [DW-1:0] r_tdata;

    logic          w_hs;
    logic          w_done;
    logic          w_load;
    logic [15:0]   w_cfg_len;
    logic [15:0]   w_len;
    logic [15:0]   w_beats;
    logic [15:0]   w_ld_p;
    logic [15:0]   w_ld_b;
    logic          w_ld_last;
    logic [KW-1:0] w_keep_last;
    logic [KW-1:0] w_ld_keep;
    logic [DW-1:0] w_pat;

    assign w_hs      = r_tvalid & axis_out_tready;
    assign w_cfg_len = (cfg_pkt_len == '0) ? 16'd1 : cfg_pkt_len;
    // In IDLE the first beat is built from the live config, afterwards from the latched copy.
    assign w_len     = (r_state == ST_IDLE) ? w_cfg_len : r_len;
    assign w_beats   = 16'((17'(w_len) + 17'(KW - 1)) / 17'(KW));
    assign w_done    = r_stop_req | stop |
                       ((r_cnt != '0) && (r_pkts_sent + 32'd1 == r_cnt));

    // Index of the beat that will be presented after the next state update.
    always_comb begin
        w_ld_p = r_p[15:0];
        w_ld_b = r_b + 16'd1;
        case (r_state)
            ST_IDLE: begin
                w_ld_p = '0;
                w_ld_b = '0;
            end
            ST_SEND: begin
                if (r_tlast) begin
                    w_ld_p = r_p[15:0] + 16'd1;
                    w_ld_b = '0;
                end
            end
            ST_GAP:  w_ld_b = '0;
            default: ;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: w_load = start;
            ST_SEND: w_load = w_hs & (~r_tlast | (~w_done & (r_gap == '0)));
            ST_GAP:  w_load = ~stop & (r_gap_cnt == '0);
            default: w_load = 1'b0;
        endcase
    end

    assign w_ld_last   = (w_ld_b == w_beats - 16'd1);
    assign w_keep_last = KW'(last_keep(w_len, KW));
    assign w_ld_keep   = w_ld_last ? w_keep_last : '1;

    axis_pkt_pattern #(.DW(DW)) u_pattern (
        .i_pkt  (w_ld_p),
        .i_beat (w_ld_b),
        .o_data (w_pat)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_p         <= '0;
            r_pkts_sent <= '0;
            r_len       <= 16'd1;
            r_beats     <= 16'd1;
            r_b         <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_stop_req  <= 1'b0;
            r_busy      <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tkeep     <= '0;
            r_tdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt       <= cfg_pkt_count;
                        r_len       <= w_cfg_len;
                        r_beats     <= w_beats;
                        r_gap       <= cfg_gap;
                        r_pkts_sent <= '0;
                        r_stop_req  <= 1'b0;
                        r_p         <= '0;
                        r_b         <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (stop)
                        r_stop_req <= 1'b1;
                    if (w_hs) begin
                        if (r_tlast) begin
                            r_pkts_sent <= r_pkts_sent + 32'd1;
                            r_p         <= r_p + 32'd1;
                            r_b         <= '0;
                            if (w_done) begin
                                r_state  <= ST_IDLE;
                                r_busy   <= 1'b0;
                                r_tvalid <= 1'b0;
                                r_tlast  <= 1'b0;
                            end else if (r_gap != '0) begin
                                r_state   <= ST_GAP;
                                r_gap_cnt <= r_gap - 8'd1;
                                r_tvalid  <= 1'b0;
                                r_tlast   <= 1'b0;
                            end
                        end else begin
                            r_b <= r_b + 16'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        r_stop_req <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end else if (r_gap_cnt == '0) begin
                        r_state <= ST_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_pat;
                r_tkeep  <= w_ld_keep;
                r_tlast  <= w_ld_last;
            end
        end
    end

    assign busy            = r_busy;
    assign pkts_sent       = r_pkts_sent;
    assign axis_out_tdata  = r_tdata;
    assign axis_out_tkeep  = r_tkeep;
    assign axis_out_tuser  = '0;
    assign axis_out_tlast  = r_tlast;
    assign axis_out_tvalid = r_tvalid;

endmodule

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
- AXI-stream packet source that drives the transmit path, typically feeding a register slice ahead of the DCMAC transmit port.
- Generates a programmable number of packets with a programmable byte length and a programmable inter-packet gap.
- Payload is a deterministic pattern, so the far-end checker can verify every byte.
- Fully honours tready backpressure.

Parameters:
- DW, 512, tdata width in bits; multiple of 32.
- KW, 64, tkeep width; equals DW/8.
- UW, 1, tuser width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; latches config and begins a run (ignored unless idle)
- stop  in  1  one-cycle pulse; ends run after current packet completes
- cfg_pkt_count  in  32  packets per run; 0 = run until stop
- cfg_pkt_len  in  16  packet length in bytes, 1..65535; 0 treated as 1
- cfg_gap  in  8  idle cycles inserted between packets
- busy  out  1  high from start acceptance until run completes
- pkts_sent  out  32  packets fully transferred in current/last run
- axis_out_tdata  out  DW  payload
- axis_out_tkeep  out  KW  byte enables
- axis_out_tuser  out  UW  always 0
- axis_out_tlast  out  1  last beat of packet
- axis_out_tvalid  out  1  beat valid
- axis_out_tready  in  1  downstream ready

Behaviour:
Reset:
- tvalid=0, tlast=0, tdata=0, tkeep=0, busy=0, pkts_sent=0, state IDLE.
- Reset mid-packet abandons the packet immediately; no tlast is emitted.

Handshake and derived values:
- Handshake: beat transfers when tvalid & tready.
- While tvalid=1 and tready=0, tdata/tkeep/tlast are held stable and tvalid is not dropped.
- beats = ceil(len/(DW/8)).
- Last-beat tkeep: low r bits set, where r = len mod KW, or all ones if r=0. All other beats have tkeep all ones.

Pattern:
- Beat b (0-based) of packet p (0-based within run): 32-bit lane i (bits 32i+31:32i) = {p[15:0], (b*(DW/32)+i)[15:0]}.
- Lanes beyond the packet's last byte are still driven with the pattern; tkeep marks them invalid.

State machine: IDLE, SEND, GAP.
- IDLE: busy=0.
  - start -> latch cfg, clear pkts_sent, clear stop_req, set p=0, b=0, enter SEND.
  - tvalid asserts the cycle after start.
- SEND: tvalid=1.
  - On each handshake, b increments.
  - On the handshake with tlast=1: pkts_sent increments, p increments.
  - Then go to IDLE if stop_req is set or if cfg_pkt_count!=0 and pkts_sent+1==cfg_pkt_count.
  - Otherwise go to GAP if cfg_gap!=0, else stay in SEND with b=0 and the next packet's first beat presented the next cycle (back-to-back, no bubble).
- GAP: tvalid=0. Counts cfg_gap cycles, then enters SEND with b=0.
- stop: sets stop_req in SEND or GAP.
  - In GAP, stop -> IDLE at once.
  - start while busy is ignored.
  - start and stop in the same cycle in IDLE: start wins, and stop is ignored.

Other rules:
- busy deasserts the cycle after the final tlast handshake.
- pkts_sent holds its value until the next start.
- Counters wrap naturally: p is 32 bits, only its low 16 bits appear in the pattern; b is 16 bits.
- No combinational path from tready to tvalid. tready only gates state advance.

Decomposition:
- Package axis_pkt_gen_pkg: state enum (IDLE, SEND, GAP) and a function that computes last-beat tkeep from len and KW.
- Optional sub-module axis_pkt_pattern: combinational lane-pattern generator from (p, b).
- No other sub-modules; a downstream slice is instantiated by the integrator, not inside this block.

Test Plan:
- Single packet: cfg_pkt_count=1, len=64, gap=0, tready=1 -> one beat, tlast=1, tkeep all ones, lane 0=0x00000000, lane 15=0x0000000F, pkts_sent=1, busy low next cycle.
- Partial last beat: len=130, count=2, gap=3 -> 3 beats per packet, last tkeep=0x3; packet 1 lane 0 of beat 0=0x00010000; exactly 3 tvalid-low cycles between packets.
- Backpressure: len=256, tready toggled pseudo-randomly -> tdata/tkeep/tlast stable while stalled; all 4 beats delivered in order with no loss or duplication.
- Back-to-back: gap=0, count=3, len=64 -> tvalid continuously high for 3 cycles, tlast on each beat, pkts_sent=3.
- Continuous and stop: count=0, len=200, stop pulsed mid-beat-2 of packet 5 -> packet 5 completes with tlast, no packet 6, pkts_sent=6, busy falls.
- Reset mid-packet: resetn low during beat 1 of len=512 -> next cycle tvalid=0, busy=0, pkts_sent=0; a fresh start after reset produces a correct packet 0.
